pipe_ctrl_unit: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/pipe_ctrl_unit_pkg.sv | 25 ++
 rtl/pipe_ctrl_unit_load_use_detect.sv | 18 +
 rtl/pipe_ctrl_unit.sv | 210 +++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared types and defaults for the pipeline sequencer.
// Enum for the control FSM, per-stage {en,flush} pair and parameter defaults.
package pipe_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } pctl_state_e;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF      = 256;
  localparam int CNT_W_DEF        = 32;

  localparam stage_ctrl_t STG_HOLD  = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STG_LOAD  = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STG_FLUSH = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipe_ctrl_unit_load_use_detect.sv
// Load-use hazard detect: load in EX whose rd feeds either source of the ID instruction.
// Purely combinational, zero latency; x0 never creates a hazard.
module load_use_detect (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  output logic       o_load_use
);

  logic w_rd_nz;
  logic w_match;

  assign w_rd_nz    = (i_ex_rd != 5'd0);
  assign w_match    = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);
  assign o_load_use = i_ex_mem_read && w_rd_nz && w_match;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline sequencer: per-stage enable/flush and PC enable from hazards, branches, memory ack and halt.
// Control outputs are combinational from state+inputs (zero latency); a pending memory access freezes every stage.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_br_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  input  logic             i_halt_req,
  input  logic             i_resume,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_flush,
  output logic             o_exmem_en,
  output logic             o_exmem_flush,
  output logic             o_memwb_en,
  output logic             o_halted,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(DRAIN_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  pctl_state_e       r_state;
  pctl_state_e       r_ret_state;
  logic [DRN_W-1:0]  r_drain_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;

  pctl_state_e       w_eff_state;
  pctl_state_e       w_state_nxt;
  pctl_state_e       w_ret_nxt;
  logic [DRN_W-1:0]  w_drain_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_wait_start;
  logic              w_wait_inc;
  logic              w_load_use;
  logic              w_memstall;
  logic              w_stall_tick;
  logic              w_pc_en;
  logic              w_memwb_en;
  logic              w_halted;
  stage_ctrl_t       w_ifid;
  stage_ctrl_t       w_idex;
  stage_ctrl_t       w_exmem;

  load_use_detect u_load_use_detect (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_ex_rd       (i_ex_rd),
    .i_ex_mem_read (i_ex_mem_read),
    .o_load_use    (w_load_use)
  );

  assign w_memstall = i_mem_req && !i_mem_ack;

  // On the ack cycle MEM_WAIT acts exactly as the state it interrupted.
  always_comb begin
    w_eff_state = r_state;
    if (r_state == ST_MEM_WAIT && i_mem_ack) begin
      w_eff_state = r_ret_state;
    end
  end

  always_comb begin
    w_pc_en      = 1'b0;
    w_ifid       = STG_HOLD;
    w_idex       = STG_HOLD;
    w_exmem      = STG_HOLD;
    w_memwb_en   = 1'b0;
    w_halted     = 1'b0;
    w_state_nxt  = w_eff_state;
    w_ret_nxt    = r_ret_state;
    w_drain_nxt  = r_drain_cnt;
    w_wait_start = 1'b0;
    w_wait_inc   = 1'b0;
    case (w_eff_state)
      ST_RUN: begin
        if (w_memstall) begin
          w_state_nxt  = ST_MEM_WAIT;
          w_ret_nxt    = ST_RUN;
          w_wait_start = 1'b1;
        end else if (i_ex_br_taken) begin
          w_pc_en    = 1'b1;
          w_ifid     = STG_FLUSH;
          w_idex     = STG_FLUSH;
          w_exmem    = STG_LOAD;
          w_memwb_en = 1'b1;
        end else if (w_load_use) begin
          w_idex     = STG_FLUSH;
          w_exmem    = STG_LOAD;
          w_memwb_en = 1'b1;
        end else if (i_halt_req) begin
          w_ifid      = STG_FLUSH;
          w_idex      = STG_LOAD;
          w_exmem     = STG_LOAD;
          w_memwb_en  = 1'b1;
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DRN_W'(1);
        end else begin
          w_pc_en    = 1'b1;
          w_ifid     = STG_LOAD;
          w_idex     = STG_LOAD;
          w_exmem    = STG_LOAD;
          w_memwb_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_memstall) begin
          w_state_nxt  = ST_MEM_WAIT;
          w_ret_nxt    = ST_DRAIN;
          w_wait_start = 1'b1;
        end else begin
          w_pc_en    = i_ex_br_taken;
          w_ifid     = STG_FLUSH;
          w_idex     = STG_LOAD;
          w_exmem    = STG_LOAD;
          w_memwb_en = 1'b1;
          if (!i_ex_br_taken && w_load_use) begin
            w_ifid = STG_HOLD;
            w_idex = STG_FLUSH;
          end else begin
            if (i_ex_br_taken) begin
              w_idex = STG_FLUSH;
            end
            if (r_drain_cnt >= DRN_LAST) begin
              w_state_nxt = ST_HALTED;
              w_drain_nxt = '0;
            end else begin
              w_drain_nxt = r_drain_cnt + DRN_W'(1);
            end
          end
        end
      end
      ST_MEM_WAIT: begin
        w_wait_inc = 1'b1;
      end
      ST_HALTED: begin
        w_halted = 1'b1;
        if (i_resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (w_wait_start) begin
      w_wait_nxt = WAIT_W'(1);
    end else if (w_wait_inc && r_wait_cnt != WAIT_MAX) begin
      w_wait_nxt = r_wait_cnt + WAIT_W'(1);
    end
  end

  assign w_stall_tick = (r_state == ST_RUN || r_state == ST_MEM_WAIT) && !w_pc_en;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_RUN;
      r_ret_state   <= ST_RUN;
      r_drain_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ret_state   <= w_ret_nxt;
      r_drain_cnt   <= w_drain_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_mem_timeout <= r_mem_timeout || (w_wait_nxt == WAIT_MAX);
      if (w_stall_tick && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Reset forces every pipeline register to take a NOP.
  assign o_pc_en       = i_reset ? 1'b0 : w_pc_en;
  assign o_ifid_en     = i_reset ? 1'b0 : w_ifid.en;
  assign o_ifid_flush  = i_reset ? 1'b1 : w_ifid.flush;
  assign o_idex_en     = i_reset ? 1'b0 : w_idex.en;
  assign o_idex_flush  = i_reset ? 1'b1 : w_idex.flush;
  assign o_exmem_en    = i_reset ? 1'b0 : w_exmem.en;
  assign o_exmem_flush = i_reset ? 1'b1 : w_exmem.flush;
  assign o_memwb_en    = i_reset ? 1'b0 : w_memwb_en;
  assign o_halted      = i_reset ? 1'b0 : w_halted;
  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: per-cycle expected control vectors queued with the stimulus.
// Vector order {pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halted}.
module tb_pipe_ctrl_unit;

  localparam logic [8:0] V_ALL    = 9'b1_10_10_10_1_0;
  localparam logic [8:0] V_FREEZE = 9'b0_00_00_00_0_0;
  localparam logic [8:0] V_RST    = 9'b0_01_01_01_0_0;
  localparam logic [8:0] V_BR     = 9'b1_11_11_10_1_0;
  localparam logic [8:0] V_LU     = 9'b0_00_11_10_1_0;
  localparam logic [8:0] V_DRAIN  = 9'b0_11_10_10_1_0;
  localparam logic [8:0] V_HALTED = 9'b0_00_00_00_0_1;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read, ex_br_taken, mem_req, mem_ack, halt_req, resume;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, halted, mem_timeout;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];

  pipe_ctrl_unit dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_br_taken (ex_br_taken),
    .i_mem_req     (mem_req),
    .i_mem_ack     (mem_ack),
    .i_halt_req    (halt_req),
    .i_resume      (resume),
    .o_pc_en       (pc_en),
    .o_ifid_en     (ifid_en),
    .o_ifid_flush  (ifid_flush),
    .o_idex_en     (idex_en),
    .o_idex_flush  (idex_flush),
    .o_exmem_en    (exmem_en),
    .o_exmem_flush (exmem_flush),
    .o_memwb_en    (memwb_en),
    .o_halted      (halted),
    .o_mem_timeout (mem_timeout),
    .o_stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle with the current inputs; expected outputs go to the scoreboard.
  task automatic cyc(input logic [8:0] exp);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_br_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      e = exp_q.pop_front();
      chk("ctrl", {23'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, exmem_flush, memwb_en, halted}, {23'd0, e});
    end
  end

  initial begin
    reset = 1'b1;
    clr_in();
    @(posedge clk);
    #1;

    cyc(V_RST);
    cyc(V_RST);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_tmo", {31'd0, mem_timeout}, 32'd0);
    reset = 1'b0;
    cyc(V_ALL);

    // load-use on rs1 then on rs2
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1;
    cyc(V_LU);
    ex_mem_read = 1'b0;
    cyc(V_ALL);
    chk("lu_stall", stall_cnt, 32'd1);
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    cyc(V_LU);
    ex_mem_read = 1'b0;
    cyc(V_ALL);
    chk("lu2_stall", stall_cnt, 32'd2);

    // x0 destination never stalls
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    cyc(V_ALL);

    // taken branch beats load-use
    ex_rd = 5'd5; id_rs1 = 5'd5; ex_br_taken = 1'b1;
    cyc(V_BR);
    clr_in();
    cyc(V_ALL);
    chk("br_stall", stall_cnt, 32'd2);

    // memory stall of three cycles, branch frozen meanwhile
    mem_req = 1'b1;
    cyc(V_FREEZE);
    ex_br_taken = 1'b1;
    cyc(V_FREEZE);
    ex_br_taken = 1'b0;
    cyc(V_FREEZE);
    mem_ack = 1'b1;
    cyc(V_ALL);
    clr_in();
    chk("mem_stall", stall_cnt, 32'd5);

    // halt, drain, halted, resume
    resume = 1'b1;
    cyc(V_ALL);
    resume = 1'b0; halt_req = 1'b1;
    cyc(V_DRAIN);
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) cyc(V_DRAIN);
    cyc(V_HALTED);
    halt_req = 1'b1;
    cyc(V_HALTED);
    resume = 1'b1;
    cyc(V_HALTED);
    clr_in();
    cyc(V_ALL);
    chk("halt_stall", stall_cnt, 32'd6);

    // drain with load-use hold, branch redirect and a memory stall in between
    halt_req = 1'b1;
    cyc(V_DRAIN);
    halt_req = 1'b0;
    cyc(V_DRAIN);
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    cyc(V_LU);
    clr_in();
    ex_br_taken = 1'b1;
    cyc(V_BR);
    ex_br_taken = 1'b0; mem_req = 1'b1;
    cyc(V_FREEZE);
    mem_ack = 1'b1;
    cyc(V_DRAIN);
    clr_in();
    cyc(V_DRAIN);
    cyc(V_HALTED);
    resume = 1'b1;
    cyc(V_HALTED);
    clr_in();
    cyc(V_ALL);

    // memory timeout at 256 waiting cycles, then reset clears it
    mem_req = 1'b1;
    for (int i = 0; i < 255; i++) cyc(V_FREEZE);
    chk("tmo_before", {31'd0, mem_timeout}, 32'd0);
    cyc(V_FREEZE);
    chk("tmo_set", {31'd0, mem_timeout}, 32'd1);
    cyc(V_FREEZE);
    chk("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
    reset = 1'b1;
    cyc(V_RST);
    chk("rst2_tmo", {31'd0, mem_timeout}, 32'd0);
    chk("rst2_stall", stall_cnt, 32'd0);
    reset = 1'b0;
    clr_in();
    cyc(V_ALL);
    cyc(V_ALL);

    @(negedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
